// File: rtl/adc_scan_if.sv
// Serial ADC link and valid/ready result port of adc_scan_ctrl.
// The master side is the scan controller.
interface adc_scan_if #(
   parameter int DATA_W = 10,
   parameter int CH_W   = 3
);
   logic              conv;
   logic              ADCclk;
   logic              ADC_in;
   logic              ADC_out;
   logic [DATA_W-1:0] data_out;
   logic [CH_W-1:0]   ch_out;
   logic              valid;
   logic              ready;
   logic              done;

   modport master (
      output conv, ADCclk, ADC_in,
      output data_out, ch_out, valid, done,
      input  ADC_out, ready
   );

   modport slave (
      input  conv, ADCclk, ADC_in,
      input  data_out, ch_out, valid, done,
      output ADC_out, ready
   );
endinterface

// File: rtl/adc_scan_ctrl.sv
// Scans the channels of a serial SAR ADC in ascending order and
// hands each result out on a valid/ready port; done marks scan end.
module adc_scan_ctrl #(
   parameter int DATA_W    = 10,
   parameter int CH_W      = 3,
   parameter int DIV       = 4,
   parameter int NULL_BITS = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               enable,
   input  logic [2**CH_W-1:0] ch_mask,
   input  logic               single,
   adc_scan_if.master         bus
);
   localparam int NCH = 2**CH_W;
   localparam int N   = 2 + CH_W + NULL_BITS + DATA_W;
   localparam int CW  = $clog2(2*DIV + 1);
   localparam int BW  = $clog2(N + 1);

   localparam logic [CW-1:0] HALF_END = CW'(DIV - 1);
   localparam logic [CW-1:0] GAP_END  = CW'(2*DIV - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(N - 1);
   localparam logic [BW-1:0] CMD_END  = BW'(2 + CH_W);
   localparam logic [BW-1:0] NUL_END  = BW'(2 + CH_W + NULL_BITS);

   typedef enum logic [2:0] {
      IDLE, SETUP, CMD, NULLB, DATA, HOLD, GAP
   } state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [BW-1:0]     bit_q, bit_d;
   logic              phase_q, phase_d;
   logic [CH_W-1:0]   ch_q, ch_d;
   logic [NCH-1:0]    mask_q, mask_d;
   logic [CH_W:0]     cmd_q, cmd_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic              conv_q, conv_d;
   logic              sclk_q, sclk_d;
   logic              din_q, din_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [CH_W-1:0]   chout_q, chout_d;
   logic              valid_q, valid_d;
   logic              done_q, done_d;
   logic              stop_q, stop_d;
   logic              arm_q, arm_d;

   logic [CH_W-1:0]   first_ch, nxt_ch, go_ch;
   logic              nxt_ok, go, tick;
   logic [BW-1:0]     nb;

   // Descending walk so the lowest qualifying channel wins.
   always_comb begin
      first_ch = '0;
      nxt_ch   = '0;
      nxt_ok   = 1'b0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (ch_mask[i]) first_ch = CH_W'(i);
         if (mask_q[i] && CH_W'(i) > ch_q) begin
            nxt_ok = 1'b1;
            nxt_ch = CH_W'(i);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      phase_d = phase_q;
      ch_d    = ch_q;
      mask_d  = mask_q;
      cmd_d   = cmd_q;
      shift_d = shift_q;
      conv_d  = conv_q;
      sclk_d  = sclk_q;
      din_d   = din_q;
      data_d  = data_q;
      chout_d = chout_q;
      valid_d = valid_q && !bus.ready;
      done_d  = 1'b0;
      stop_d  = stop_q;
      arm_d   = 1'b1;
      go      = 1'b0;
      go_ch   = ch_q;
      tick    = (cnt_q == HALF_END);
      nb      = bit_q + 1'b1;
      unique case (state_q)
         IDLE: begin
            stop_d = 1'b0;
            if (arm_q && enable && |ch_mask) begin
               mask_d = ch_mask;
               go     = 1'b1;
               go_ch  = first_ch;
            end
         end
         SETUP, CMD, NULLB, DATA: begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
            if (!enable) begin
               state_d = IDLE;
               cnt_d   = '0;
               conv_d  = 1'b0;
               sclk_d  = 1'b0;
               din_d   = 1'b0;
            end else if (tick) begin
               if (state_q == SETUP) begin
                  state_d = CMD;
                  bit_d   = '0;
                  phase_d = 1'b0;
               end else if (!phase_q) begin
                  phase_d = 1'b1;
                  sclk_d  = 1'b1;
               end else begin
                  phase_d = 1'b0;
                  sclk_d  = 1'b0;
                  if (state_q == DATA)
                     shift_d = {shift_q[DATA_W-2:0], bus.ADC_out};
                  if (bit_q == LAST_BIT) begin
                     state_d = HOLD;
                     conv_d  = 1'b0;
                     din_d   = 1'b0;
                  end else begin
                     bit_d = nb;
                     din_d = cmd_q[CH_W];
                     cmd_d = {cmd_q[CH_W-1:0], 1'b0};
                     if (nb < CMD_END)      state_d = CMD;
                     else if (nb < NUL_END) state_d = NULLB;
                     else                   state_d = DATA;
                  end
               end
            end
         end
         HOLD: begin
            if (!enable) stop_d = 1'b1;
            // Loading in the same edge as a handshake keeps valid high.
            if (!valid_q || bus.ready) begin
               data_d  = shift_q;
               chout_d = ch_q;
               valid_d = 1'b1;
               cnt_d   = '0;
               if (!enable || stop_q) begin
                  state_d = IDLE;
               end else begin
                  state_d = GAP;
                  done_d  = !nxt_ok;
               end
            end
         end
         GAP: begin
            if (!enable) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == GAP_END) begin
               cnt_d = '0;
               if (nxt_ok) begin
                  go    = 1'b1;
                  go_ch = nxt_ch;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (go) begin
         state_d = SETUP;
         cnt_d   = '0;
         ch_d    = go_ch;
         cmd_d   = {single, go_ch};
         shift_d = '0;
         conv_d  = 1'b1;
         sclk_d  = 1'b0;
         din_d   = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         phase_q <= 1'b0;
         ch_q    <= '0;
         mask_q  <= '0;
         cmd_q   <= '0;
         shift_q <= '0;
         conv_q  <= 1'b0;
         sclk_q  <= 1'b0;
         din_q   <= 1'b0;
         data_q  <= '0;
         chout_q <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         stop_q  <= 1'b0;
         arm_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         phase_q <= phase_d;
         ch_q    <= ch_d;
         mask_q  <= mask_d;
         cmd_q   <= cmd_d;
         shift_q <= shift_d;
         conv_q  <= conv_d;
         sclk_q  <= sclk_d;
         din_q   <= din_d;
         data_q  <= data_d;
         chout_q <= chout_d;
         valid_q <= valid_d;
         done_q  <= done_d;
         stop_q  <= stop_d;
         arm_q   <= arm_d;
      end
   end

   assign bus.conv     = conv_q;
   assign bus.ADCclk   = sclk_q;
   assign bus.ADC_in   = din_q;
   assign bus.data_out = data_q;
   assign bus.ch_out   = chout_q;
   assign bus.valid    = valid_q;
   assign bus.done     = done_q;
endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Scoreboard bench for adc_scan_ctrl: an ADC model answers each frame,
// expected results are queued per scan and popped on each handshake.
module tb_adc_scan_ctrl;
   localparam int DW  = 10;
   localparam int CW  = 3;
   localparam int DIV = 1;
   localparam int NB  = 1;
   localparam int NCH = 2**CW;
   localparam int N   = 2 + CW + NB + DW;
   localparam int LAT = DIV * (1 + 2*N) + 1;

   typedef struct {
      logic [CW-1:0] ch;
      logic [DW-1:0] data;
      bit            last;
   } res_t;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           enable = 1'b0;
   logic           single = 1'b0;
   logic [NCH-1:0] ch_mask = '0;

   adc_scan_if #(.DATA_W(DW), .CH_W(CW)) bus ();

   adc_scan_ctrl #(
      .DATA_W(DW), .CH_W(CW), .DIV(DIV), .NULL_BITS(NB)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable),
      .ch_mask(ch_mask), .single(single), .bus(bus)
   );

   always #5 clk = ~clk;

   res_t          expq[$];
   int            frq[$];
   logic [DW-1:0] words [NCH];
   int            checks = 0;
   int            errors = 0;
   int            exp_done = 0;
   int            done_cnt = 0;
   int            conv_rises = 0;
   int            rdy_mode = 1;
   bit            chk_lat = 1'b0;

   int            cyc = 0, rise_cyc = 0, rises = 0;
   int            low_run = 0, cur_ch = 0;
   logic [N-1:0]  cap, exp_cmd;
   logic [DW-1:0] w;
   logic          pconv = 1'b0, psclk = 1'b0, pvalid = 1'b0;

   // ADC model and frame observer.
   always @(posedge clk) begin
      #1;
      cyc++;
      if (!rst_n) begin
         rises = 0; low_run = 0;
         pconv = 1'b0; psclk = 1'b0; pvalid = 1'b0;
      end else begin
         if (bus.conv && !pconv) begin
            conv_rises++;
            rise_cyc = cyc;
            rises = 0;
            cap = '0;
            checks++;
            if (low_run < 2*DIV || frq.size() == 0) begin
               errors++;
               $display("FAIL frame_start low_run=%0d need>=%0d queued=%0d",
                        low_run, 2*DIV, frq.size());
            end
            cur_ch = (frq.size() != 0) ? frq.pop_front() : 0;
         end
         if (bus.ADCclk && !psclk && bus.conv) begin
            rises++;
            if (rises <= N) begin
               cap[N-rises] = bus.ADC_in;
               w = words[cur_ch];
               if (rises > N - DW) bus.ADC_out = w[N-rises];
               else                bus.ADC_out = 1'($urandom);
            end
         end
         if (!bus.conv && pconv && rises == N) begin
            checks++;
            exp_cmd = {1'b1, single, CW'(cur_ch), {(N-2-CW){1'b0}}};
            if (cap !== exp_cmd) begin
               errors++;
               $display("FAIL cmd_bits got=%b need=%b", cap, exp_cmd);
            end
         end
         low_run = bus.conv ? 0 : low_run + 1;
         if (bus.valid && !pvalid && chk_lat) begin
            checks++;
            if (cyc - rise_cyc != LAT) begin
               errors++;
               $display("FAIL valid_latency got=%0d need=%0d",
                        cyc - rise_cyc, LAT);
            end
         end
         pconv = bus.conv;
         psclk = bus.ADCclk;
         pvalid = bus.valid;
      end
   end

   always @(posedge clk) begin
      #1;
      if (rdy_mode == 0)      bus.ready = 1'b0;
      else if (rdy_mode == 1) bus.ready = 1'b1;
      else if (rdy_mode == 2) bus.ready = 1'($urandom);
   end

   // Scoreboard monitor.
   always @(negedge clk) begin
      res_t e;
      if (rst_n) begin
         if (bus.done) begin
            done_cnt++;
            checks++;
            if (expq.size() == 0 || !bus.valid || !expq[0].last ||
                bus.ch_out !== expq[0].ch ||
                bus.data_out !== expq[0].data) begin
               errors++;
               $display("FAIL done got ch=%0d data=%h valid=%b need last result",
                        bus.ch_out, bus.data_out, bus.valid);
            end
         end
         if (bus.valid && bus.ready) begin
            checks++;
            if (expq.size() == 0) begin
               errors++;
               $display("FAIL result got ch=%0d data=%h need none",
                        bus.ch_out, bus.data_out);
            end else begin
               e = expq.pop_front();
               if (bus.ch_out !== e.ch || bus.data_out !== e.data) begin
                  errors++;
                  $display("FAIL result got ch=%0d data=%h need ch=%0d data=%h",
                           bus.ch_out, bus.data_out, e.ch, e.data);
               end
            end
         end
      end
   end

   task automatic step(int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic new_words();
      for (int i = 0; i < NCH; i++) words[i] = DW'($urandom);
   endtask

   task automatic start_scan(logic [NCH-1:0] m, logic s);
      int   hi;
      res_t r;
      hi = 0;
      for (int i = 0; i < NCH; i++) if (m[i]) hi = i;
      for (int i = 0; i < NCH; i++) begin
         if (m[i]) begin
            r.ch = CW'(i);
            r.data = words[i];
            r.last = (i == hi);
            expq.push_back(r);
            frq.push_back(i);
         end
      end
      exp_done++;
      single = s;
      ch_mask = m;
      enable = 1'b1;
   endtask

   task automatic wait_done(int lim);
      int i;
      i = 0;
      while (!bus.done && i < lim) begin
         step(1);
         i++;
      end
      checks++;
      if (!bus.done) begin
         errors++;
         $display("FAIL done_timeout got done=0 need 1 within %0d", lim);
      end
      enable = 1'b0;
   endtask

   task automatic drain(int lim);
      int i;
      i = 0;
      while (expq.size() != 0 && i < lim) begin
         step(1);
         i++;
      end
      checks++;
      if (expq.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d left need 0", expq.size());
      end
      step(4);
   endtask

   task automatic wait_conv(int lim);
      int i;
      i = 0;
      while (!bus.conv && i < lim) begin
         step(1);
         i++;
      end
      checks++;
      if (!bus.conv) begin
         errors++;
         $display("FAIL conv_timeout got conv=0 need 1");
      end
   endtask

   task automatic chk_zero(string nm);
      checks++;
      if (bus.conv !== 1'b0 || bus.ADCclk !== 1'b0 ||
          bus.ADC_in !== 1'b0 || bus.valid !== 1'b0 ||
          bus.done !== 1'b0 || bus.data_out !== '0 ||
          bus.ch_out !== '0) begin
         errors++;
         $display("FAIL %s got conv=%b sclk=%b din=%b v=%b d=%b data=%h ch=%0d need all 0",
                  nm, bus.conv, bus.ADCclk, bus.ADC_in, bus.valid,
                  bus.done, bus.data_out, bus.ch_out);
      end
   endtask

   initial begin
      int i, n0;
      logic [NCH-1:0] m;
      bus.ready = 1'b1;
      bus.ADC_out = 1'b0;
      for (int k = 0; k < NCH; k++) words[k] = '0;
      repeat (3) @(posedge clk);
      #2;
      chk_zero("reset_state");
      rst_n = 1'b1;
      step(3);

      // Single channel with a known word.
      rdy_mode = 1;
      chk_lat = 1'b1;
      words[2] = 10'h2D5;
      start_scan(8'h04, 1'b1);
      wait_done(200);
      drain(100);

      // Sparse mask, channels 0, 2, 7.
      new_words();
      start_scan(8'h85, 1'b0);
      wait_done(400);
      drain(100);
      chk_lat = 1'b0;

      // Backpressure: second result waits while first is held.
      rdy_mode = 3;
      bus.ready = 1'b0;
      new_words();
      start_scan(8'h03, 1'b1);
      step(90);
      checks++;
      if (bus.valid !== 1'b1 || bus.ch_out !== 3'd0 ||
          bus.data_out !== words[0] || bus.conv !== 1'b0 ||
          bus.done !== 1'b0) begin
         errors++;
         $display("FAIL hold got v=%b ch=%0d data=%h conv=%b need v=1 ch=0 data=%h conv=0",
                  bus.valid, bus.ch_out, bus.data_out, bus.conv, words[0]);
      end
      bus.ready = 1'b1;
      step(1);
      bus.ready = 1'b0;
      wait_done(1);
      rdy_mode = 1;
      drain(50);

      // Random scans, random backpressure, mask scrambled mid-scan.
      rdy_mode = 2;
      for (int t = 0; t < 8; t++) begin
         new_words();
         m = NCH'($urandom_range(1, NCH - 1));
         start_scan(m, 1'($urandom));
         step(5);
         ch_mask = NCH'($urandom);
         wait_done(1000);
         drain(300);
      end

      // Abort during DATA.
      rdy_mode = 1;
      new_words();
      frq.push_back(0);
      single = 1'b0;
      ch_mask = 8'h01;
      enable = 1'b1;
      wait_conv(20);
      i = 0;
      while (rises < 10 && i < 100) begin
         step(1);
         i++;
      end
      checks++;
      if (rises < 10) begin
         errors++;
         $display("FAIL abort_wait got rises=%0d need 10", rises);
      end
      enable = 1'b0;
      step(1);
      checks++;
      if (bus.conv !== 1'b0 || bus.ADCclk !== 1'b0 || bus.ADC_in !== 1'b0) begin
         errors++;
         $display("FAIL abort_lines got conv=%b sclk=%b din=%b need 0",
                  bus.conv, bus.ADCclk, bus.ADC_in);
      end
      step(40);
      checks++;
      if (bus.valid !== 1'b0 || done_cnt != exp_done) begin
         errors++;
         $display("FAIL abort_result got v=%b done=%0d need v=0 done=%0d",
                  bus.valid, done_cnt, exp_done);
      end

      // Reset during CMD, then an empty mask never starts a frame.
      words[1] = DW'($urandom);
      frq.push_back(1);
      single = 1'b1;
      ch_mask = 8'h02;
      enable = 1'b1;
      wait_conv(20);
      step(3);
      rst_n = 1'b0;
      #1;
      chk_zero("async_reset");
      step(2);
      rst_n = 1'b1;
      ch_mask = '0;
      enable = 1'b1;
      n0 = conv_rises;
      step(100);
      checks++;
      if (conv_rises != n0 || bus.conv !== 1'b0) begin
         errors++;
         $display("FAIL empty_mask got rises=%0d conv=%b need rises=%0d conv=0",
                  conv_rises, bus.conv, n0);
      end
      enable = 1'b0;
      step(2);

      checks++;
      if (expq.size() != 0 || frq.size() != 0) begin
         errors++;
         $display("FAIL queues got res=%0d frames=%0d need 0 0",
                  expq.size(), frq.size());
      end
      checks++;
      if (done_cnt != exp_done) begin
         errors++;
         $display("FAIL done_count got %0d need %0d", done_cnt, exp_done);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
